// File: rtl/nrisc_multiciclo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nrisc_multiciclo : multi-cycle 4-register RISC core, req/ack memory ports
// Revision 1.0
// ----------------------------------------------------------------------------
module nrisc_multiciclo #(
  parameter int WIDTH = 8,
  parameter int PCW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             instr_req,
  output logic [PCW-1:0]   instr_addr,
  input  logic             instr_ack,
  input  logic [7:0]       instr_data,
  output logic             data_req,
  output logic             data_we,
  output logic [WIDTH-1:0] data_addr,
  output logic [WIDTH-1:0] data_wdata,
  input  logic             data_ack,
  input  logic [WIDTH-1:0] data_rdata,
  output logic             halted,
  output logic [PCW-1:0]   pc_out
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_LI   = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JR   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [PCW-1:0]   pc;
  logic [7:0]       ir;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] alu;
  logic [WIDTH-1:0] regs [4];

  logic [3:0] op;
  logic [1:0] ra;
  logic [1:0] rb;
  logic       fetch_done;
  logic       mem_done;

  assign op = ir[7:4];
  assign ra = ir[3:2];
  assign rb = ir[1:0];

  // Acks only count while the matching request is actually outstanding.
  assign fetch_done = instr_req & instr_ack;
  assign mem_done   = data_req & data_ack;

  assign instr_addr = pc;
  assign pc_out     = pc;
  assign data_addr  = op_b;
  assign data_wdata = op_a;
  assign halted     = (state == HALT);

  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = op_a + op_b;
      OP_SUB:  alu = op_a - op_b;
      OP_AND:  alu = op_a & op_b;
      OP_OR:   alu = op_a | op_b;
      OP_SLT:  alu = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_LI:   alu = {{(WIDTH-2){rb[1]}}, rb};
      default: alu = '0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:  if (fetch_done) next_state = DECODE;
      DECODE: next_state = EXEC;
      EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_LI: next_state = WB;
          OP_LD, OP_ST: next_state = MEM;
          OP_HALT:      next_state = HALT;
          default:      next_state = FETCH;
        endcase
      end
      MEM:     if (mem_done) next_state = (op == OP_LD) ? WB : FETCH;
      WB:      next_state = FETCH;
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= '0;
      ir        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      result    <= '0;
      instr_req <= 1'b0;
      data_req  <= 1'b0;
      data_we   <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      state <= next_state;
      // Requests are registered from the next state, so they appear with the state itself.
      instr_req <= (next_state == FETCH);
      data_req  <= (next_state == MEM);
      case (state)
        FETCH: begin
          if (fetch_done) begin
            ir <= instr_data;
            pc <= pc + {{(PCW-1){1'b0}}, 1'b1};
          end
        end
        DECODE: begin
          op_a <= regs[ra];
          op_b <= regs[rb];
        end
        EXEC: begin
          result <= alu;
          if (op == OP_BEQ && op_a == '0) pc <= PCW'(op_b);
          if (op == OP_JR) pc <= PCW'(op_a);
          if (next_state == MEM) data_we <= (op == OP_ST);
        end
        MEM: begin
          if (mem_done) begin
            data_we <= 1'b0;
            if (op == OP_LD) result <= data_rdata;
          end
        end
        WB:      regs[ra] <= result;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nrisc_multiciclo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_nrisc_multiciclo : program vectors plus store scoreboard for the core
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_nrisc_multiciclo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req;
  logic [3:0]  instr_addr;
  logic        instr_ack = 1'b0;
  logic [7:0]  instr_data = 8'h00;
  logic        data_req;
  logic        data_we;
  logic [15:0] data_addr;
  logic [15:0] data_wdata;
  logic        data_ack = 1'b0;
  logic [15:0] data_rdata = 16'h0000;
  logic        halted;
  logic [3:0]  pc_out;

  nrisc_multiciclo #(.WIDTH(16), .PCW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_req  (instr_req),
    .instr_addr (instr_addr),
    .instr_ack  (instr_ack),
    .instr_data (instr_data),
    .data_req   (data_req),
    .data_we    (data_we),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_ack   (data_ack),
    .data_rdata (data_rdata),
    .halted     (halted),
    .pc_out     (pc_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:15][7:0] prog;
    logic [3:0]       iwait;
    logic [3:0]       dwait;
    logic             spur;
    logic [1:0]       nst;
    logic [31:0]      e0;
    logic [31:0]      e1;
    logic [3:0]       pc;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  logic [7:0]  imem [16];
  logic [15:0] dmem [16];
  int          n_pass = 0;
  int          n_total = 0;
  int          iwait = 0;
  int          dwait = 0;
  logic        spur = 1'b0;
  int          icnt = 0;
  int          dcnt = 0;
  int          dmin = 99;
  int          dmax = 0;
  logic        overlap = 1'b0;
  logic        unstable = 1'b0;
  logic [3:0]  isave;
  logic [32:0] dsave;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memory responder: zero or more wait cycles per request, optional stray acks while idle.
  always @(negedge clk) begin : resp
    logic [31:0] e;
    if (instr_req && data_req) overlap = 1'b1;
    if (instr_req) begin
      if (icnt == 0) isave = instr_addr;
      else if (instr_addr != isave) unstable = 1'b1;
      if (icnt >= iwait) begin
        instr_ack  = 1'b1;
        instr_data = imem[instr_addr];
        icnt = 0;
      end else begin
        instr_ack = 1'b0;
        icnt++;
      end
    end else begin
      icnt = 0;
      instr_ack  = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      instr_data = 8'($urandom);
    end
    if (data_req) begin
      if (dcnt == 0) dsave = {data_we, data_addr, data_wdata};
      else if ({data_we, data_addr, data_wdata} != dsave) unstable = 1'b1;
      if (dcnt >= dwait) begin
        data_ack = 1'b1;
        if (dcnt + 1 < dmin) dmin = dcnt + 1;
        if (dcnt + 1 > dmax) dmax = dcnt + 1;
        dcnt = 0;
        if (data_we) begin
          dmem[data_addr[3:0]] = data_wdata;
          if (sb.size() == 0) begin
            n_total++;
            $display("FAIL store: got addr %h data %h, expected no store", data_addr, data_wdata);
          end else begin
            e = sb.pop_front();
            check("store", {data_addr, data_wdata}, e);
          end
        end else begin
          data_rdata = dmem[data_addr[3:0]];
        end
      end else begin
        data_ack = 1'b0;
        dcnt++;
      end
    end else begin
      dcnt = 0;
      data_ack   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      data_rdata = 16'($urandom);
    end
  end

  task automatic add(input logic [0:15][7:0] p, input int iw, input int dw, input logic sp,
                     input int nst, input logic [31:0] e0, input logic [31:0] e1, input logic [3:0] pc);
    vec_t v;
    v.prog = p; v.iwait = 4'(iw); v.dwait = 4'(dw); v.spur = sp;
    v.nst = 2'(nst); v.e0 = e0; v.e1 = e1; v.pc = pc;
    vecs.push_back(v);
  endtask

  task automatic load(input logic [0:15][7:0] p);
    for (int i = 0; i < 16; i++) imem[i] = p[i];
    for (int i = 0; i < 16; i++) dmem[i] = 16'h0000;
    dmem[0] = 16'h00A5;
  endtask

  task automatic wait_halt(input int limit);
    int c = 0;
    while (!halted && c < limit) begin
      @(negedge clk);
      c++;
    end
    check("halted", 32'(halted), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    rst_n = 1'b0;
    iwait = int'(v.iwait); dwait = int'(v.dwait); spur = v.spur;
    load(v.prog);
    sb.delete();
    if (v.nst > 0) sb.push_back(v.e0);
    if (v.nst > 1) sb.push_back(v.e1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_halt(600);
    check("final_pc", 32'(pc_out), 32'(v.pc));
    check("stores_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin : main
    int c;
    // Zero-wait ADD program: reset values, request rise, 4+4+4+3 cycle timing.
    load({8'h55, 8'h5B, 8'h06, 8'hF0, {12{8'hF0}}});
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_instr_req", 32'(instr_req), 32'd0);
    check("rst_data_req", 32'(data_req), 32'd0);
    check("rst_data_we", 32'(data_we), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", 32'(pc_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("req_after_reset", 32'(instr_req), 32'd1);
    c = 0;
    while (!halted && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("add_prog_cycles", 32'(c), 32'd15);
    check("add_prog_pc", 32'(pc_out), 32'd4);
    spur = 1'b1;
    repeat (6) @(negedge clk);
    check("halt_pc_frozen", 32'(pc_out), 32'd4);
    check("halt_still", 32'(halted), 32'd1);
    check("halt_no_ireq", 32'(instr_req), 32'd0);
    check("halt_no_dreq", 32'(data_req), 32'd0);

    // Program table: {code, instr waits, data waits, stray acks, #stores, stores, final PC}.
    add({8'h55, 8'h5B, 8'h06, 8'h74, 8'hF0, {11{8'hF0}}}, 0, 0, 0, 1, 32'h0000_0000, 0, 4'd5);
    add({8'h56, 8'h59, 8'h46, 8'h74, 8'hF0, {11{8'hF0}}}, 1, 2, 0, 1, 32'h0000_0001, 0, 4'd5);
    add({8'h5B, 8'h1A, 8'h78, 8'hF0, {12{8'hF0}}}, 0, 0, 1, 1, 32'h0000_0000, 0, 4'd4);
    add({8'h57, 8'h5A, 8'h26, 8'h74, 8'hF0, {11{8'hF0}}}, 0, 1, 0, 1, 32'h0000_FFFE, 0, 4'd5);
    add({8'h56, 8'h59, 8'h36, 8'h74, 8'hF0, {11{8'hF0}}}, 2, 0, 0, 1, 32'h0000_FFFF, 0, 4'd5);
    add({8'h55, 8'h5A, 8'h46, 8'h74, 8'hF0, {11{8'hF0}}}, 0, 0, 1, 1, 32'h0000_0000, 0, 4'd5);
    add({8'h57, 8'h05, 8'h74, 8'hF0, {12{8'hF0}}}, 1, 1, 0, 1, 32'h0000_FFFE, 0, 4'd4);
    add({8'h55, 8'h05, 8'h05, 8'h05, 8'h81, 8'h5D, 8'h7C, 8'hF0, 8'h5E, 8'h7C, 8'hF0, {5{8'hF0}}},
        0, 0, 0, 1, 32'h0000_FFFE, 0, 4'd11);
    add({8'h51, 8'h55, 8'h05, 8'h05, 8'h05, 8'h81, 8'h5D, 8'h7C, 8'hF0, {7{8'hF0}}},
        0, 0, 1, 1, 32'h0001_0001, 0, 4'd9);
    add({8'h0D, 8'h57, 8'h8D, 8'h7C, 8'hF0, {10{8'hF0}}, 8'hA0}, 1, 0, 0, 1, 32'h0000_FFFF, 0, 4'd5);
    add({8'h55, 8'h05, 8'h05, 8'h05, 8'h94, 8'h5D, 8'h7C, 8'hF0, 8'h5E, 8'h7C, 8'hF0, {5{8'hF0}}},
        0, 1, 1, 1, 32'h0000_FFFE, 0, 4'd11);
    add({8'h6C, 8'h55, 8'h7D, 8'h69, 8'h78, 8'hF0, {10{8'hF0}}}, 1, 2, 1, 2,
        32'h0001_00A5, 32'h0000_00A5, 4'd6);
    for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k]);

    // Store then load with three data wait cycles each.
    rst_n = 1'b0;
    iwait = 0; dwait = 3; spur = 1'b0;
    load({8'h6C, 8'h7C, 8'h68, 8'h79, 8'hF0, {11{8'hF0}}});
    sb.delete();
    sb.push_back(32'h0000_00A5);
    sb.push_back(32'h0000_00A5);
    dmin = 99; dmax = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    c = 0;
    while (!(instr_req && instr_addr == 4'd2) && c < 100) begin
      @(negedge clk);
      c++;
    end
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(instr_req && instr_addr == 4'd3) && c < 50);
    check("ld_wait_latency", 32'(c), 32'd8);
    wait_halt(200);
    check("mem_pc", 32'(pc_out), 32'd5);
    check("mem_stores_left", 32'(sb.size()), 32'd0);
    check("dreq_len_min", 32'(dmin), 32'd4);
    check("dreq_len_max", 32'(dmax), 32'd4);

    // Reset in the middle of a load, with a late ack just after reset.
    rst_n = 1'b0;
    iwait = 0; dwait = 15; spur = 1'b0;
    load({8'h55, 8'h64, 8'hF0, {13{8'hF0}}});
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    c = 0;
    while (!data_req && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("mid_ld_dreq", 32'(data_req), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_mid_dreq", 32'(data_req), 32'd0);
    check("rst_mid_pc", 32'(pc_out), 32'd0);
    load({8'h74, 8'hF0, {14{8'hF0}}});
    sb.push_back(32'h0000_0000);
    dwait = 0;
    data_ack = 1'b1;
    instr_ack = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ireq", 32'(instr_req), 32'd1);
    check("rst_mid_iaddr", 32'(instr_addr), 32'd0);
    check("rst_mid_no_dreq", 32'(data_req), 32'd0);
    wait_halt(200);
    check("rst_mid_pc_end", 32'(pc_out), 32'd2);
    check("rst_mid_stores", 32'(sb.size()), 32'd0);

    check("req_overlap", 32'(overlap), 32'd0);
    check("req_stable", 32'(unstable), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
